// File: rtl/fft_frame_ctrl_if.sv
// Sample-in / frame-out stream bundle of the FFT frame scheduler.
// slave: the scheduler's view; master: the producer/consumer side.
interface fft_frame_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  sample_valid;
  logic [DATA_WIDTH-1:0] sample_in;
  logic                  fft_valid;
  logic                  fft_first;
  logic [DATA_WIDTH-1:0] fft_data;
  logic                  swap_valid;

  modport slave (
    input  sample_valid,
    input  sample_in,
    input  swap_valid,
    output fft_valid,
    output fft_first,
    output fft_data
  );

  modport master (
    output sample_valid,
    output sample_in,
    output swap_valid,
    input  fft_valid,
    input  fft_first,
    input  fft_data
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frame scheduler ahead of the FFT / bin-reorder pipeline.
// Samples go into a ring of N_FFT+HOP entries; overlapping N_FFT-sample
// frames (hop HOP) are replayed oldest-first as one contiguous burst, and
// the next frame waits for N_FFT/2 spectrum beats from the reorder stage.
module fft_frame_ctrl #(
  parameter int N_FFT           = 256,
  parameter int HOP             = 128,
  parameter int DATA_WIDTH      = 16,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       spi_en_inf_system_sync,
  fft_frame_ctrl_if.slave            bus,
  output logic                       frame_done,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt,
  output logic                       overrun,
  output logic                       busy
);

  localparam int D  = N_FFT + HOP;
  localparam int AW = $clog2(D);
  localparam int CW = $clog2(N_FFT + 1);
  localparam int IW = $clog2(N_FFT);

  localparam logic [AW-1:0] LAST_A    = AW'(D - 1);
  localparam logic [AW-1:0] N_FFT_A   = AW'(N_FFT);
  localparam logic [AW-1:0] HOP_A     = AW'(HOP);
  localparam logic [CW-1:0] N_FFT_C   = CW'(N_FFT);
  localparam logic [CW-1:0] HOP_C     = CW'(HOP);
  localparam logic [IW-1:0] ISSUE_END = IW'(N_FFT - 1);
  localparam logic [IW-1:0] SWAP_END  = IW'(N_FFT / 2 - 1);

  typedef enum logic [1:0] {IDLE, FILL, ISSUE, WAIT} state_t;

  state_t                     state_r;
  logic [AW-1:0]              wr_ptr_r;
  logic [AW-1:0]              rd_ptr_r;
  logic [CW-1:0]              new_cnt_r;
  logic [IW-1:0]              issue_cnt_r;
  logic [IW-1:0]              swap_cnt_r;
  logic                       first_frame_r;
  logic                       fft_valid_r;
  logic                       fft_first_r;
  logic [DATA_WIDTH-1:0]      fft_data_r;
  logic                       frame_done_r;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_r;
  logic                       overrun_r;
  logic                       busy_r;

  logic                       accept_s;
  logic                       drop_s;
  logic [AW-1:0]              wr_ptr_nxt_s;
  logic [CW-1:0]              new_cnt_nxt_s;
  logic [CW-1:0]              thresh_s;
  logic [AW-1:0]              launch_ptr_s;

  logic [DATA_WIDTH-1:0]      mem [0:D-1];

  // Ring pointers wrap explicitly because the depth is not a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_A) ? '0 : p + AW'(1);
  endfunction

  // Oldest sample of a frame whose newest sample sits just before p.
  function automatic logic [AW-1:0] frame_start(input logic [AW-1:0] p);
    return (p >= N_FFT_A) ? p - N_FFT_A : p + HOP_A;
  endfunction

  assign bus.fft_valid = fft_valid_r;
  assign bus.fft_first = fft_first_r;
  assign bus.fft_data  = fft_data_r;
  assign frame_done    = frame_done_r;
  assign frame_cnt     = frame_cnt_r;
  assign overrun       = overrun_r;
  assign busy          = busy_r;

  // Decide whether this cycle's sample is stored or dropped, and the resulting pointer/count.
  always_comb begin
    accept_s = 1'b0;
    drop_s   = 1'b0;
    case (state_r)
      FILL: begin
        accept_s = spi_en_inf_system_sync & bus.sample_valid;
      end
      ISSUE, WAIT: begin
        // A full hop is already buffered: a further sample would overwrite unread data.
        if (new_cnt_r == HOP_C) begin
          drop_s = spi_en_inf_system_sync & bus.sample_valid;
        end else begin
          accept_s = spi_en_inf_system_sync & bus.sample_valid;
        end
      end
      default: begin
        accept_s = 1'b0;
        drop_s   = 1'b0;
      end
    endcase
    wr_ptr_nxt_s  = accept_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
    new_cnt_nxt_s = accept_s ? new_cnt_r + CW'(1) : new_cnt_r;
    thresh_s      = first_frame_r ? N_FFT_C : HOP_C;
    launch_ptr_s  = frame_start(wr_ptr_nxt_s);
  end

  // Sample ring write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (rst_n && accept_s) begin
      mem[wr_ptr_r] <= bus.sample_in;
    end
  end

  // Frame scheduler FSM with registered stream and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n || !spi_en_inf_system_sync) begin
      // Reset and disable both abort at once; a restart refills a whole frame.
      state_r       <= IDLE;
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      new_cnt_r     <= '0;
      issue_cnt_r   <= '0;
      swap_cnt_r    <= '0;
      first_frame_r <= 1'b0;
      fft_valid_r   <= 1'b0;
      fft_first_r   <= 1'b0;
      fft_data_r    <= '0;
      frame_done_r  <= 1'b0;
      frame_cnt_r   <= '0;
      overrun_r     <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      fft_valid_r  <= 1'b0;
      fft_first_r  <= 1'b0;
      frame_done_r <= 1'b0;
      wr_ptr_r     <= wr_ptr_nxt_s;
      new_cnt_r    <= new_cnt_nxt_s;
      if (drop_s) begin
        overrun_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          state_r       <= FILL;
          first_frame_r <= 1'b1;
          busy_r        <= 1'b0;
        end
        FILL: begin
          if (accept_s && (new_cnt_nxt_s == thresh_s)) begin
            state_r       <= ISSUE;
            rd_ptr_r      <= launch_ptr_s;
            new_cnt_r     <= '0;
            first_frame_r <= 1'b0;
            issue_cnt_r   <= '0;
            busy_r        <= 1'b1;
          end
        end
        ISSUE: begin
          fft_valid_r <= 1'b1;
          fft_first_r <= (issue_cnt_r == '0);
          fft_data_r  <= mem[rd_ptr_r];
          rd_ptr_r    <= ptr_inc(rd_ptr_r);
          issue_cnt_r <= issue_cnt_r + IW'(1);
          if (issue_cnt_r == ISSUE_END) begin
            state_r     <= WAIT;
            issue_cnt_r <= '0;
            swap_cnt_r  <= '0;
          end
        end
        WAIT: begin
          if (bus.swap_valid) begin
            if (swap_cnt_r == SWAP_END) begin
              frame_done_r <= 1'b1;
              frame_cnt_r  <= frame_cnt_r + FRAME_CNT_WIDTH'(1);
              swap_cnt_r   <= '0;
              // A full hop already buffered launches the next frame straight away.
              if (new_cnt_nxt_s == HOP_C) begin
                state_r     <= ISSUE;
                rd_ptr_r    <= launch_ptr_s;
                new_cnt_r   <= '0;
                issue_cnt_r <= '0;
                busy_r      <= 1'b1;
              end else begin
                state_r <= FILL;
                busy_r  <= 1'b0;
              end
            end else begin
              swap_cnt_r <= swap_cnt_r + IW'(1);
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl (N_FFT=256, HOP=128).
// Inputs change 1 time unit after posedge; outputs are logged at negedge.
module tb_fft_frame_ctrl;
  localparam int N   = 256;
  localparam int HOP = 128;
  localparam int DW  = 16;
  localparam int FCW = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic           frame_done;
  logic [FCW-1:0] frame_cnt;
  logic           overrun;
  logic           busy;

  fft_frame_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  fft_frame_ctrl #(
    .N_FFT(N), .HOP(HOP), .DATA_WIDTH(DW), .FRAME_CNT_WIDTH(FCW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .spi_en_inf_system_sync(en),
    .bus(bus),
    .frame_done(frame_done),
    .frame_cnt(frame_cnt),
    .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] beat_q[$];
  bit            first_q[$];
  int            bcyc_q[$];
  int            done_cnt = 0;
  int            done_cyc = -1;

  // Log every FFT beat and frame_done pulse.
  always @(negedge clk) begin
    if (bus.fft_valid) begin
      beat_q.push_back(bus.fft_data);
      first_q.push_back(bus.fft_first);
      bcyc_q.push_back(cyc);
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  int errors = 0;
  int checks = 0;
  int last_strobe = 0;
  int ovr_base = 0;
  int abort_base = 0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic feed(input int start, input int count, input int period);
    for (int i = 0; i < count; i++) begin
      bus.sample_valid = 1'b1;
      bus.sample_in    = DW'(start + i);
      last_strobe      = cyc;
      step(1);
      bus.sample_valid = 1'b0;
      if (period > 1) step(period - 1);
    end
  endtask

  task automatic wait_beats(input int target, input int budget);
    for (int n = 0; n < budget && beat_q.size() < target; n++) step(1);
  endtask

  // Reorder-stage model: nbeats swap_valid pulses, delay cycles after the frame's last beat.
  task automatic reorder(input int end_beat, input int delay, input int nbeats);
    wait_beats(end_beat, 3000);
    step(delay);
    repeat (nbeats) begin
      bus.swap_valid = 1'b1;
      step(1);
    end
    bus.swap_valid = 1'b0;
  endtask

  function automatic int first_bad(input int b, input int start, input int n);
    if (beat_q.size() < b + n) return -2;
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] e;
      e = DW'(start + i);
      if (beat_q[b + i] !== e) return i;
    end
    return -1;
  endfunction

  function automatic bit shape_ok(input int b);
    if (beat_q.size() < b + N) return 1'b0;
    if (first_q[b] !== 1'b1) return 1'b0;
    for (int i = 1; i < N; i++) begin
      if (bcyc_q[b + i] != bcyc_q[b + i - 1] + 1) return 1'b0;
      if (first_q[b + i] !== 1'b0) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int beat_cyc(input int i);
    return (i < bcyc_q.size()) ? bcyc_q[i] : -1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_in = '0;
    bus.swap_valid = 1'b0;
    step(3);
    checks++; if (bus.fft_valid !== 1'b0) begin errors++; $display("FAIL reset_fft_valid: got %b expected 0", bus.fft_valid); end
    checks++; if (bus.fft_first !== 1'b0) begin errors++; $display("FAIL reset_fft_first: got %b expected 0", bus.fft_first); end
    checks++; if (bus.fft_data !== 16'd0) begin errors++; $display("FAIL reset_fft_data: got %0h expected 0", bus.fft_data); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    step(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_first_frame();
    int b;
    int t;
    en = 1'b1;
    step(2);
    b = beat_q.size();
    // swap_valid during FILL must be ignored
    repeat (5) begin
      bus.swap_valid = 1'b1;
      step(1);
    end
    bus.swap_valid = 1'b0;
    feed(0, N, 4);
    t = last_strobe;
    wait_beats(b + N, 400);
    checks++; if (beat_q.size() !== b + N) begin errors++; $display("FAIL f1_beats: got %0d expected %0d", beat_q.size() - b, N); end
    checks++; if (first_bad(b, 0, N) !== -1) begin errors++; $display("FAIL f1_data: bad index %0d expected -1", first_bad(b, 0, N)); end
    checks++; if (shape_ok(b) !== 1'b1) begin errors++; $display("FAIL f1_shape: got %b expected 1", shape_ok(b)); end
    checks++; if (beat_cyc(b) !== t + 2) begin errors++; $display("FAIL f1_latency: got cycle %0d expected %0d", beat_cyc(b), t + 2); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL f1_busy_wait: got %b expected 1", busy); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL f1_no_done: got %0d expected 0", done_cnt); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL f1_frame_cnt: got %0d expected 0", frame_cnt); end
  endtask

  task automatic test_second_frame();
    int d0;
    d0 = done_cnt;
    fork
      feed(N, HOP, 2);
      reorder(N, 300, N / 2);
    join
    step(1);
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL f1_done: got %0d expected %0d", done_cnt, d0 + 1); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL f1_frame_cnt_done: got %0d expected 1", frame_cnt); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL f2_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_streaming();
    int f1;
    int dc;
    f1 = done_cyc;
    dc = done_cnt;
    fork
      feed(N + HOP, HOP, 3);
      begin
        reorder(2 * N, 300, N / 2);
        step(1);
      end
    join
    checks++; if (first_bad(N, HOP, N) !== -1) begin errors++; $display("FAIL f2_data: bad index %0d expected -1", first_bad(N, HOP, N)); end
    checks++; if (shape_ok(N) !== 1'b1) begin errors++; $display("FAIL f2_shape: got %b expected 1", shape_ok(N)); end
    checks++; if (beat_cyc(N) !== f1 + 1) begin errors++; $display("FAIL f2_launch: got cycle %0d expected %0d", beat_cyc(N), f1 + 1); end
    checks++; if (done_cnt !== dc + 1) begin errors++; $display("FAIL f2_done: got %0d expected %0d", done_cnt, dc + 1); end
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL f2_frame_cnt: got %0d expected 2", frame_cnt); end
    wait_beats(3 * N, 400);
    checks++; if (first_bad(2 * N, N, N) !== -1) begin errors++; $display("FAIL f3_data: bad index %0d expected -1", first_bad(2 * N, N, N)); end
    checks++; if (shape_ok(2 * N) !== 1'b1) begin errors++; $display("FAIL f3_shape: got %b expected 1", shape_ok(2 * N)); end
    checks++; if (beat_cyc(2 * N) !== done_cyc + 1) begin errors++; $display("FAIL f3_launch: got cycle %0d expected %0d", beat_cyc(2 * N), done_cyc + 1); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL f3_overrun: got %b expected 0", overrun); end
    reorder(3 * N, 20, N / 2);
    step(1);
    checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL f3_frame_cnt: got %0d expected 3", frame_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL f3_busy_fill: got %b expected 0", busy); end
  endtask

  task automatic test_overrun();
    int b;
    int f;
    en = 1'b0;
    step(2);
    en = 1'b1;
    step(2);
    b = beat_q.size();
    feed(1000, N, 1);
    wait_beats(b + N, 300);
    feed(1000 + N, HOP, 1);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_128: got %b expected 0", overrun); end
    feed(1000 + N + HOP, 1, 1);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_129: got %b expected 1", overrun); end
    f = done_cnt;
    reorder(b + N, 10, N / 2);
    step(1);
    checks++; if (done_cnt !== f + 1) begin errors++; $display("FAIL ovr_done: got %0d expected %0d", done_cnt, f + 1); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL ovr_frame_cnt: got %0d expected 1", frame_cnt); end
    wait_beats(b + N + 1, 10);
    checks++; if (beat_cyc(b + N) !== done_cyc + 1) begin errors++; $display("FAIL ovr_launch: got cycle %0d expected %0d", beat_cyc(b + N), done_cyc + 1); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    ovr_base = b + N;
  endtask

  task automatic test_abort();
    int sz;
    int rb;
    int t;
    wait_beats(ovr_base + 100, 200);
    // frame 2 must start at 1128; the dropped 1384 would only show at its tail
    checks++; if (first_bad(ovr_base, 1000 + HOP, 100) !== -1) begin errors++; $display("FAIL ovr_f2_data: bad index %0d expected -1", first_bad(ovr_base, 1000 + HOP, 100)); end
    en = 1'b0;
    step(1);
    checks++; if (bus.fft_valid !== 1'b0) begin errors++; $display("FAIL abort_fft_valid: got %b expected 0", bus.fft_valid); end
    checks++; if (bus.fft_first !== 1'b0) begin errors++; $display("FAIL abort_fft_first: got %b expected 0", bus.fft_first); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL abort_frame_cnt: got %0d expected 0", frame_cnt); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL abort_overrun: got %b expected 0", overrun); end
    sz = beat_q.size();
    step(5);
    checks++; if (beat_q.size() !== sz) begin errors++; $display("FAIL abort_quiet: got %0d beats expected %0d", beat_q.size(), sz); end
    en = 1'b1;
    step(2);
    rb = beat_q.size();
    feed(2000, N - 1, 1);
    step(20);
    checks++; if (beat_q.size() !== rb) begin errors++; $display("FAIL refill_early: got %0d beats expected %0d", beat_q.size(), rb); end
    feed(2000 + N - 1, 1, 1);
    t = last_strobe;
    wait_beats(rb + N, 300);
    checks++; if (first_bad(rb, 2000, N) !== -1) begin errors++; $display("FAIL refill_data: bad index %0d expected -1", first_bad(rb, 2000, N)); end
    checks++; if (shape_ok(rb) !== 1'b1) begin errors++; $display("FAIL refill_shape: got %b expected 1", shape_ok(rb)); end
    checks++; if (beat_cyc(rb) !== t + 2) begin errors++; $display("FAIL refill_latency: got cycle %0d expected %0d", beat_cyc(rb), t + 2); end
    abort_base = rb;
  endtask

  task automatic test_reset_in_wait();
    int d;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rw_busy: got %b expected 1", busy); end
    reorder(abort_base + N, 5, N / 2);
    step(1);
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL rw_frame_cnt: got %0d expected 1", frame_cnt); end
    feed(2000 + N, HOP, 1);
    wait_beats(abort_base + 2 * N, 300);
    checks++; if (first_bad(abort_base + N, 2000 + HOP, N) !== -1) begin errors++; $display("FAIL rw_data: bad index %0d expected -1", first_bad(abort_base + N, 2000 + HOP, N)); end
    feed(2000 + N + HOP, HOP + 1, 1);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL rw_overrun: got %b expected 1", overrun); end
    d = done_cnt;
    repeat (N / 2 - 1) begin
      bus.swap_valid = 1'b1;
      step(1);
    end
    bus.swap_valid = 1'b1;
    rst_n = 1'b0;
    step(1);
    bus.swap_valid = 1'b0;
    checks++; if (bus.fft_valid !== 1'b0) begin errors++; $display("FAIL rw_fft_valid: got %b expected 0", bus.fft_valid); end
    checks++; if (bus.fft_first !== 1'b0) begin errors++; $display("FAIL rw_fft_first: got %b expected 0", bus.fft_first); end
    checks++; if (bus.fft_data !== 16'd0) begin errors++; $display("FAIL rw_fft_data: got %0h expected 0", bus.fft_data); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rw_frame_done: got %b expected 0", frame_done); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rw_frame_cnt0: got %0d expected 0", frame_cnt); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rw_overrun0: got %b expected 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rw_busy0: got %b expected 0", busy); end
    step(3);
    checks++; if (done_cnt !== d) begin errors++; $display("FAIL rw_no_done: got %0d expected %0d", done_cnt, d); end
    rst_n = 1'b1;
    step(2);
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    bus.swap_valid   = 1'b0;
    test_reset();
    test_first_frame();
    test_second_frame();
    test_streaming();
    test_overrun();
    test_abort();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
